// File: rtl/jtag_debug_pkg.sv
// Shared types and constants for the JTAG debug hub: FSM state encoding,
// hub identification magic and the DR frame-length helper.
package jtag_debug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [15:0] HUB_MAGIC = 16'hD6B1;

  // A DR frame is {data, wr, ch}, shifted LSB-first.
  function automatic int frame_w(input int ch_w, input int data_w);
    return data_w + 1 + ch_w;
  endfunction

endpackage

// File: rtl/bscan_sync.sv
// Synchroniser bank for raw BSCAN signals: STAGES metastability flops, then one
// extra flop that provides a delayed level and a registered rising-edge pulse.
module bscan_sync #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      level <= '0;
      rise  <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      level <= stage[STAGES-1];
      rise  <= stage[STAGES-1] & ~level;
    end
  end

endmodule

// File: rtl/jtag_debug_hub.sv
// JTAG debug hub: oversamples a BSCAN user chain, decodes {data, wr, ch} DR frames
// and routes writes/readback to NUM_CH channels. Optional ID channel: JTAG_DEBUG_HUB_ID_EN.
module jtag_debug_hub
  import jtag_debug_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     drck_in,
  input  logic                     tdi_in,
  input  logic                     shift_in,
  input  logic                     capture_in,
  input  logic                     update_in,
  input  logic                     sel_in,
  input  logic                     jtag_reset_in,
  output logic                     tdo_out,
  output logic [NUM_CH*DATA_W-1:0] ctrl_data,
  output logic [NUM_CH-1:0]        ctrl_wr,
  input  logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     frame_err
);

  localparam int FRAME_W = frame_w(CH_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1) + 1;
`ifdef JTAG_DEBUG_HUB_ID_EN
  localparam logic [31:0]     ID_WORD = {HUB_MAGIC, 8'(NUM_CH), 8'(DATA_W)};
  localparam logic [CH_W-1:0] ID_CH   = CH_W'(2**CH_W - 1);
`endif

  logic [6:0] lvl, rise;
  bscan_sync #(.WIDTH(7), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   ({jtag_reset_in, sel_in, update_in, capture_in, shift_in, tdi_in, drck_in}),
    .level (lvl),
    .rise  (rise)
  );

  logic jrst_s, sel_s, capture_s, shift_s, tdi_s;
  logic ev_upd, ev_cap, ev_shf;
  logic unused_sync;
  assign jrst_s      = lvl[6];
  assign sel_s       = lvl[5];
  assign capture_s   = lvl[3];
  assign shift_s     = lvl[2];
  assign tdi_s       = lvl[1];
  assign unused_sync = ^{rise[6:5], rise[3:1], lvl[4], lvl[0]};
  assign ev_upd      = rise[4] & sel_s;
  assign ev_cap      = rise[0] & capture_s & sel_s;
  assign ev_shf      = rise[0] & shift_s & sel_s;

  state_t state, state_nx;
  logic   do_load, do_shift, do_commit, do_empty;

  logic [FRAME_W-1:0] sr;
  logic [CNT_W-1:0]   bitcnt;
  logic [CH_W-1:0]    cur_ch;
  logic [DATA_W-1:0]  cap_word;
  logic [NUM_CH-1:0]  wr_hit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    if (jrst_s) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (ev_cap && !ev_upd) state_nx = CAPT;
        CAPT:    if (ev_upd) state_nx = IDLE;
                 else if (ev_shf && !ev_cap) state_nx = SHIFT;
        SHIFT:   if (ev_upd) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Update outranks capture, which outranks shift, on a coincident edge.
  always_comb begin
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    do_empty  = 1'b0;
    if (!jrst_s) begin
      unique case (state)
        IDLE:  do_load = ev_cap & ~ev_upd;
        CAPT: begin
          do_empty = ev_upd;
          do_load  = ev_cap & ~ev_upd;
          do_shift = ev_shf & ~ev_cap & ~ev_upd;
        end
        SHIFT: begin
          do_commit = ev_upd;
          do_shift  = ev_shf & ~ev_upd;
        end
        default: ;
      endcase
    end
  end

  // Reserved channels read back zero unless they are the ID channel.
  always_comb begin
    cap_word = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (cur_ch == CH_W'(k)) cap_word = rd_data[k*DATA_W +: DATA_W];
`ifdef JTAG_DEBUG_HUB_ID_EN
    if (cur_ch == ID_CH) cap_word = DATA_W'(ID_WORD);
`endif
  end

  // Writes to reserved or ID indices never match a real channel and are dropped.
  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NUM_CH; k++)
      wr_hit[k] = sr[CH_W] && (sr[CH_W-1:0] == CH_W'(k));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      bitcnt    <= '0;
      cur_ch    <= '0;
      ctrl_data <= '0;
      ctrl_wr   <= '0;
      frame_err <= 1'b0;
    end else begin
      ctrl_wr   <= '0;
      frame_err <= 1'b0;
      if (jrst_s) begin
        sr     <= '0;
        bitcnt <= '0;
        cur_ch <= '0;
      end else if (do_commit) begin
        if (bitcnt != CNT_W'(FRAME_W)) begin
          frame_err <= 1'b1;
        end else begin
          cur_ch <= sr[CH_W-1:0];
          for (int k = 0; k < NUM_CH; k++) begin
            if (wr_hit[k]) ctrl_data[k*DATA_W +: DATA_W] <= sr[FRAME_W-1 -: DATA_W];
          end
          ctrl_wr <= wr_hit;
        end
      end else if (do_empty) begin
        frame_err <= 1'b1;
      end else if (do_load) begin
        sr     <= {cap_word, 1'b0, cur_ch};
        bitcnt <= '0;
      end else if (do_shift) begin
        sr <= {tdi_s, sr[FRAME_W-1:1]};
        if (bitcnt != '1) bitcnt <= bitcnt + CNT_W'(1);
      end
    end
  end

  assign tdo_out = sr[0];

endmodule

// File: tb/tb_jtag_debug_hub.sv
// Self-checking bench for jtag_debug_hub: directed scans plus randomized frames
// compared against a frame-level reference model of channel data and readback.
module tb_jtag_debug_hub;

  localparam int NUM_CH  = 3;
  localparam int CH_W    = 2;
  localparam int DATA_W  = 32;
  localparam int SYNC    = 2;
  localparam int FRAME_W = DATA_W + 1 + CH_W;

  logic clk = 1'b0;
  logic reset, drck_in, tdi_in, shift_in, capture_in, update_in, sel_in, jtag_reset_in;
  logic tdo_out, frame_err;
  logic [NUM_CH*DATA_W-1:0] ctrl_data, rd_data;
  logic [NUM_CH-1:0]        ctrl_wr;

  jtag_debug_hub #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .reset         (reset),
    .drck_in       (drck_in),
    .tdi_in        (tdi_in),
    .shift_in      (shift_in),
    .capture_in    (capture_in),
    .update_in     (update_in),
    .sel_in        (sel_in),
    .jtag_reset_in (jtag_reset_in),
    .tdo_out       (tdo_out),
    .ctrl_data     (ctrl_data),
    .ctrl_wr       (ctrl_wr),
    .rd_data       (rd_data),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Pulse monitor: counts strobe cycles and error cycles seen mid-clock.
  int wr_cnt  = 0;
  int err_cnt = 0;
  logic [NUM_CH-1:0] wr_last = '0;
  always @(negedge clk) begin
    if (ctrl_wr != '0) begin
      wr_cnt++;
      wr_last = ctrl_wr;
    end
    if (frame_err) err_cnt++;
  end

  // Reference model: last written word per channel and the selected channel.
  logic [DATA_W-1:0] m_data [NUM_CH];
  logic [CH_W-1:0]   m_cur;

  function automatic logic [DATA_W-1:0] rd_word(input int c);
    if (c < NUM_CH) return rd_data[c*DATA_W +: DATA_W];
`ifdef JTAG_DEBUG_HUB_ID_EN
    if (c == 2**CH_W - 1) return {16'hD6B1, 8'(NUM_CH), 8'(DATA_W)};
`endif
    return '0;
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] model_ctrl();
    logic [NUM_CH*DATA_W-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k*DATA_W +: DATA_W] = m_data[k];
    return v;
  endfunction

  task automatic clock_bit(input logic b, output logic seen);
    tdi_in = b;
    #20;
    seen = tdo_out;
    #20;
    drck_in = 1'b1;
    #40;
    drck_in = 1'b0;
  endtask

  task automatic capture_phase();
    logic d;
    capture_in = 1'b1;
    clock_bit(1'b0, d);
    capture_in = 1'b0;
    shift_in   = 1'b1;
  endtask

  task automatic shift_bits(input logic [FRAME_W-1:0] frame, input int n, input bit drop,
                            output logic [FRAME_W-1:0] seen);
    logic b, s;
    seen = '0;
    for (int i = 0; i < n; i++) begin
      if (drop && i == n/2) begin
        sel_in = 1'b0;
        clock_bit(1'($urandom), s);
        clock_bit(1'($urandom), s);
        sel_in = 1'b1;
      end
      if (i < FRAME_W) b = frame[i];
      else b = 1'($urandom);
      clock_bit(b, s);
      if (i < FRAME_W) seen[i] = s;
    end
    shift_in = 1'b0;
    #40;
  endtask

  // Raises update between clock edges and reports the clk count to the strobe.
  task automatic update_phase(output int lat);
    update_in = 1'b1;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && ctrl_wr != '0) lat = n;
    end
    #4;
    update_in = 1'b0;
    #80;
  endtask

  task automatic run_scan(input string tag, input logic wr, input logic [CH_W-1:0] ch,
                          input logic [DATA_W-1:0] data, input int nshift, input bit drop);
    logic [FRAME_W-1:0] frame, exp_cap, seen, mask;
    logic [NUM_CH-1:0]  exp_wr;
    logic               exp_err;
    int                 wr0, err0, lat;
    frame   = {data, wr, ch};
    exp_cap = {rd_word(int'(m_cur)), 1'b0, m_cur};
    capture_phase();
    shift_bits(frame, nshift, drop, seen);
    mask = '0;
    for (int i = 0; i < FRAME_W; i++) mask[i] = (i < nshift);
    if (nshift > 0) check({tag, "_capture"}, seen & mask, exp_cap & mask);

    exp_err = (nshift != FRAME_W);
    exp_wr  = '0;
    if (!exp_err) begin
      m_cur = ch;
      if (wr && int'(ch) < NUM_CH) begin
        m_data[ch] = data;
        exp_wr[ch] = 1'b1;
      end
    end
    wr0  = wr_cnt;
    err0 = err_cnt;
    update_phase(lat);
    check({tag, "_err_pulses"}, err_cnt - err0, int'(exp_err));
    check({tag, "_wr_pulses"}, wr_cnt - wr0, int'(exp_wr != '0));
    if (exp_wr != '0) begin
      check({tag, "_wr_strobe"}, wr_last, exp_wr);
      check({tag, "_wr_latency"}, lat, SYNC + 2);
    end
    check({tag, "_ctrl_data"}, ctrl_data, model_ctrl());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [FRAME_W-1:0] seen;
    int wr0, err0, lat;

    reset = 1'b1; drck_in = 1'b0; tdi_in = 1'b0; shift_in = 1'b0; capture_in = 1'b0;
    update_in = 1'b0; sel_in = 1'b0; jtag_reset_in = 1'b0; rd_data = '0;
    for (int k = 0; k < NUM_CH; k++) m_data[k] = '0;
    m_cur = '0;
    #100;
    reset = 1'b0;
    #50;
    check("reset_tdo", tdo_out, 1'b0);
    check("reset_ctrl_data", ctrl_data, '0);
    check("reset_ctrl_wr", ctrl_wr, '0);
    check("reset_frame_err", frame_err, 1'b0);
    sel_in = 1'b1;
    #80;

    // Write, two-scan read, short frame, reserved channel.
    rd_data = {$urandom, $urandom, $urandom};
    run_scan("write_ch2", 1'b1, 2'd2, 32'hDEADBEEF, FRAME_W, 1'b0);
    run_scan("read_sel_ch1", 1'b0, 2'd1, $urandom, FRAME_W, 1'b0);
    rd_data[1*DATA_W +: DATA_W] = 32'h12345678;
    run_scan("read_ch1", 1'b0, 2'd1, $urandom, FRAME_W, 1'b0);
    run_scan("short_frame", 1'b1, 2'd0, $urandom, FRAME_W - 1, 1'b0);
    run_scan("reserved_wr", 1'b1, 2'd3, 32'hCAFEF00D, FRAME_W, 1'b0);
    run_scan("reserved_rd", 1'b0, 2'd0, $urandom, FRAME_W, 1'b0);
    run_scan("empty_frame", 1'b1, 2'd1, $urandom, 0, 1'b0);

    // TAP reset mid-frame: selection returns to channel 0, data is kept.
    capture_phase();
    shift_bits({32'h0BADF00D, 1'b1, 2'd1}, 20, 1'b0, seen);
    jtag_reset_in = 1'b1;
    #80;
    jtag_reset_in = 1'b0;
    #80;
    check("jrst_tdo", tdo_out, 1'b0);
    check("jrst_ctrl_data", ctrl_data, model_ctrl());
    m_cur = '0;
    wr0 = wr_cnt;
    err0 = err_cnt;
    update_phase(lat);
    check("jrst_update_wr", wr_cnt - wr0, 0);
    check("jrst_update_err", err_cnt - err0, 0);
    run_scan("after_jrst", 1'b1, 2'd1, $urandom, FRAME_W, 1'b0);

    // System reset during SHIFT clears all outputs on the next edge.
    capture_phase();
    shift_bits({$urandom, 1'b1, 2'd0}, 12, 1'b0, seen);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("sysrst_ctrl_data", ctrl_data, '0);
    check("sysrst_ctrl_wr", ctrl_wr, '0);
    check("sysrst_tdo", tdo_out, 1'b0);
    check("sysrst_frame_err", frame_err, 1'b0);
    #44;
    reset = 1'b0;
    for (int k = 0; k < NUM_CH; k++) m_data[k] = '0;
    m_cur = '0;
    #80;
    run_scan("after_sysrst", 1'b1, 2'd0, $urandom, FRAME_W, 1'b0);

    // Randomized frames, including bad lengths and deselected edges.
    for (int t = 0; t < 30; t++) begin
      int r, n;
      r = int'($urandom_range(0, 9));
      n = (r == 0) ? 0 : (r == 1) ? FRAME_W - 1 : (r == 2) ? FRAME_W + 1 : FRAME_W;
      rd_data = {$urandom, $urandom, $urandom};
      run_scan($sformatf("rand%0d", t), 1'($urandom), 2'($urandom), $urandom, n,
               ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
